// File: rtl/seq_engine.sv
// seq_engine: Simon Says sequence store, LED playback timer and move judge (define SEQ_FIXED_SEED_EN to seed the LFSR with 16'hACE1)
module seq_engine #(
  parameter int unsigned BASE_TICKS = 25_000_000,
  parameter int unsigned SPEED_STEP = 2_500_000,
  parameter int unsigned MIN_TICKS  = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rst_seed,
  input  logic       start_rng,
  input  logic       add_clr,
  input  logic       inc_speed,
  input  logic       pulse_on,
  input  logic       judge,
  input  logic [3:0] player_input,
  output logic [3:0] led,
  output logic [5:0] check_round,
  output logic       pulse,
  output logic       result,
  output logic [5:0] current_round
);
  typedef enum logic [1:0] {IDLE, PLAY, TURN} phase_t;
  phase_t phase, phase_nx;
  logic [15:0] seed, lfsr, seed_val;
  logic [1:0] mem [32];
  logic [5:0] idx;
  logic [31:0] period, step_period, cnt;
  logic run, append, show, hit, miss, last_done;
  logic [3:0] exp_clr;
`ifdef SEQ_FIXED_SEED_EN
  assign seed_val = 16'hACE1;
`else
  assign seed_val = (seed == 16'h0000) ? 16'h0001 : seed;
`endif
  assign exp_clr   = 4'b0001 << mem[idx[4:0]];
  assign result    = phase == TURN && player_input == exp_clr;
  assign append    = add_clr && current_round < 6'd32;
  assign show      = !add_clr && pulse_on && phase == PLAY && check_round != 6'd0;
  assign hit       = !add_clr && !pulse_on && judge && phase == TURN && result;
  assign miss      = !add_clr && !pulse_on && judge && phase == TURN && !result;
  assign last_done = !add_clr && pulse && phase == PLAY && check_round == 6'd0;
  // phase register
  always_ff @(posedge clk or negedge reset)
    if (!reset) phase <= IDLE;
    else phase <= phase_nx;
  // phase transitions: append arms playback, last pulse hands over to the player, a wrong move ends the game
  always_comb begin
    phase_nx = phase;
    phase_nx = append ? PLAY : last_done ? TURN : miss ? IDLE : phase;
  end
  // free-running seed counter and LFSR that steps once per appended colour
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      seed <= 16'h0000;
      lfsr <= 16'h0001;
    end else begin
      seed <= rst_seed ? 16'h0000 : seed + 16'h0001;
      if (start_rng) lfsr <= seed_val;
      else if (append) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  // colour memory needs no reset: only entries below current_round are ever read meaningfully
  always_ff @(posedge clk)
    if (append) mem[current_round[4:0]] <= lfsr[1:0];
  // step period shrinks per inc_speed, clamped at the floor
  always_ff @(posedge clk or negedge reset)
    if (!reset) period <= BASE_TICKS;
    else if (inc_speed) period <= (period >= MIN_TICKS + SPEED_STEP) ? period - SPEED_STEP : MIN_TICKS;
  // playback step timer, round bookkeeping and LED drive
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      led           <= 4'b0000;
      check_round   <= 6'd0;
      current_round <= 6'd0;
      idx           <= 6'd0;
      pulse         <= 1'b0;
      run           <= 1'b0;
      cnt           <= 32'd0;
      step_period   <= BASE_TICKS;
    end else begin
      pulse <= run && cnt == step_period - 32'd1;
      if (run) begin
        cnt <= cnt + 32'd1;
        if (cnt == step_period - 32'd1) run <= 1'b0;
        if (cnt == step_period / 2 - 32'd1) led <= 4'b0000;
      end
      if (append) begin
        idx           <= 6'd0;
        check_round   <= current_round + 6'd1;
        current_round <= current_round + 6'd1;
        led           <= 4'b0000;
      end else if (show) begin
        led         <= exp_clr;
        idx         <= idx + 6'd1;
        check_round <= check_round - 6'd1;
        cnt         <= 32'd0;
        run         <= 1'b1;
        step_period <= period;
      end else if (last_done) begin
        idx         <= 6'd0;
        check_round <= current_round;
      end else if (hit && check_round != 6'd0) begin
        idx         <= idx + 6'd1;
        check_round <= check_round - 6'd1;
      end
    end
endmodule

// File: tb/tb_seq_engine.sv
// tb_seq_engine: table and scoreboard checks of seq_engine playback, judging, saturation and reset
module tb_seq_engine;
  localparam int BT = 8, MT = 4, ST = 2;
`ifdef SEQ_FIXED_SEED_EN
  localparam logic [3:0] HIT = 4'b0010;
`else
  localparam logic [3:0] HIT = 4'b0100;
`endif
  logic clk = 0, reset = 0, rst_seed = 0, start_rng = 0, add_clr = 0;
  logic inc_speed = 0, pulse_on = 0, judge = 0;
  logic [3:0] player_input = 4'b0000;
  logic [3:0] led;
  logic [5:0] check_round, current_round;
  logic pulse, result;
  int passed = 0, total = 0;
  logic [3:0] exp_q [$];
  logic [1:0] m_mem [32];
  logic [15:0] m_lfsr = 16'h0001;
  int m_cr = 0, m_idx = 0, m_chk = 0, m_period = BT;
  typedef struct {logic [3:0] pi; logic res;} vec_t;
  vec_t tbl [7];

  seq_engine #(.BASE_TICKS(BT), .SPEED_STEP(ST), .MIN_TICKS(MT)) dut (
    .clk(clk), .reset(reset), .rst_seed(rst_seed), .start_rng(start_rng),
    .add_clr(add_clr), .inc_speed(inc_speed), .pulse_on(pulse_on), .judge(judge),
    .player_input(player_input), .led(led), .check_round(check_round),
    .pulse(pulse), .result(result), .current_round(current_round));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  task automatic seed_load(input int gap);
    rst_seed = 1; tick; rst_seed = 0;
    repeat (gap - 1) tick;
    start_rng = 1; tick; start_rng = 0;
`ifdef SEQ_FIXED_SEED_EN
    m_lfsr = 16'hACE1;
`else
    m_lfsr = (gap == 1) ? 16'h0001 : 16'(gap - 1);
`endif
  endtask

  task automatic do_add;
    add_clr = 1; tick; add_clr = 0;
    if (m_cr < 32) begin
      m_mem[m_cr] = m_lfsr[1:0];
      m_lfsr = nxt(m_lfsr);
      m_cr++;
      m_chk = m_cr;
      m_idx = 0;
    end
    chk("current_round_add", current_round, m_cr);
    chk("check_round_add", check_round, m_chk);
  endtask

  task automatic do_inc;
    inc_speed = 1; tick; inc_speed = 0;
    m_period = (m_period - ST < MT) ? MT : m_period - ST;
  endtask

  task automatic play_step(input bit inc_mid, input bit last);
    int on, at, sp;
    logic [3:0] e;
    sp = m_period;
    exp_q.push_back(oh(m_mem[m_idx]));
    m_idx++;
    m_chk--;
    pulse_on = 1; tick; pulse_on = 0;
    e = exp_q.pop_front();
    chk("led_colour", led, e);
    chk("check_round_step", check_round, m_chk);
    on = 0;
    at = -1;
    for (int n = 0; n < 40; n++) begin
      if (led != 0) on++;
      if (pulse) begin
        at = n;
        break;
      end
      if (inc_mid && n == 2) begin
        inc_speed = 1;
        m_period = (m_period - ST < MT) ? MT : m_period - ST;
      end
      tick;
      inc_speed = 0;
    end
    chk("led_on_cycles", on, sp / 2);
    chk("pulse_delay", at, sp);
    chk("check_round_at_pulse", check_round, m_chk);
    tick;
    chk("pulse_one_cycle", pulse, 0);
    if (last) begin
      m_idx = 0;
      m_chk = m_cr;
      chk("check_round_turn", check_round, m_chk);
    end
  endtask

  task automatic play_round;
    for (int i = 0; i < m_cr; i++) play_step(1'b0, i == m_cr - 1);
  endtask

  task automatic do_judge(input logic [3:0] pi, input logic res);
    player_input = pi;
    #1;
    chk("result_judge", result, res);
    judge = 1; tick; judge = 0;
    if (res) begin
      m_idx++;
      m_chk--;
    end
    chk("check_round_judge", check_round, m_chk);
  endtask

  initial begin
    int pc;
    logic [3:0] w;
    tbl[0] = '{HIT, 1'b1};
    tbl[1] = '{4'b0000, 1'b0};
    tbl[2] = '{4'b1111, 1'b0};
    tbl[3] = '{HIT | (HIT >> 1), 1'b0};
    tbl[4] = '{HIT | 4'b1000, 1'b0};
    tbl[5] = '{4'b1000, 1'b0};
    tbl[6] = '{4'b0001, 1'b0};
    player_input = HIT;
    tick; tick;
    chk("reset_led", led, 0);
    chk("reset_check_round", check_round, 0);
    chk("reset_current_round", current_round, 0);
    chk("reset_pulse", pulse, 0);
    chk("reset_result", result, 0);
    reset = 1;
    tick;
    seed_load(3);
    do_add;
    play_round;
    for (int i = 0; i < 7; i++) begin
      player_input = tbl[i].pi;
      #1;
      chk("result_table", result, tbl[i].res);
    end
    do_judge(HIT, 1'b1);
    do_add;
    player_input = HIT;
    #1;
    chk("result_outside_turn", result, 0);
    play_round;
    do_judge(oh(m_mem[0]), 1'b1);
    w = oh(m_mem[1]);
    w = w | ((w == 4'b0001) ? 4'b0010 : 4'b0001);
    do_judge(w, 1'b0);
    player_input = oh(m_mem[1]);
    #1;
    chk("result_idle", result, 0);
    do_add;
    play_step(1'b1, 1'b0);
    play_step(1'b0, 1'b0);
    play_step(1'b0, 1'b1);
    do_inc;
    do_inc;
    do_add;
    play_round;
    while (m_cr < 32) do_add;
    do_add;
    chk("saturated_round", current_round, 32);
    play_round;
    reset = 0; tick; reset = 1; tick;
    m_lfsr = 16'h0001;
    m_cr = 0;
    m_period = BT;
    seed_load(1);
    do_add;
    pulse_on = 1; tick; pulse_on = 0;
    chk("zero_seed_colour", led, oh(m_mem[0]));
    tick; tick; tick;
    reset = 0;
    #1;
    chk("midreset_led", led, 0);
    chk("midreset_check_round", check_round, 0);
    chk("midreset_current_round", current_round, 0);
    chk("midreset_pulse", pulse, 0);
    chk("midreset_result", result, 0);
    tick;
    reset = 1;
    pc = 0;
    for (int n = 0; n < 12; n++) begin
      tick;
      if (pulse) pc++;
    end
    chk("no_pulse_after_reset", pc, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
